// File: rtl/sample_tick_generator_pkg.sv
// Shared audio timing package: tick FSM state encoding and divisor defaults.
package sample_tick_generator_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} tick_state_t;

   localparam int unsigned DEFAULT_DIVISOR     = 1136;
   localparam int unsigned MIN_DIVISOR_DEFAULT = 2;
endpackage

// File: rtl/sample_tick_generator_divisor_sanitiser.sv
// divisor_sanitiser: combinational clamp of a requested period up to MIN_DIVISOR.
module divisor_sanitiser
   import sample_tick_generator_pkg::*;
#(
   parameter int          WIDTH       = 32,
   parameter int unsigned MIN_DIVISOR = MIN_DIVISOR_DEFAULT
) (
   input  logic [WIDTH-1:0] divisor_in,
   output logic [WIDTH-1:0] divisor_out
);
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_DIVISOR);

   assign divisor_out = (divisor_in < MIN_V) ? MIN_V : divisor_in;
endmodule

// File: rtl/sample_tick_generator.sv
// sample_tick_generator: one-cycle sample_tick every active_divisor clocks.
// Define SAMPLE_DIV_CLK_EN to add the 50%-duty div_clk output.
module sample_tick_generator
   import sample_tick_generator_pkg::*;
#(
   parameter int          WIDTH       = 32,
   parameter int unsigned MIN_DIVISOR = MIN_DIVISOR_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             restart,
   input  logic [WIDTH-1:0] frequency_divisor,
   output logic             sample_tick,
   output logic [WIDTH-1:0] active_divisor,
   output logic [15:0]      tick_count
`ifdef SAMPLE_DIV_CLK_EN
  ,output logic             div_clk
`endif
);
   tick_state_t      state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] s_div;
   logic             terminal;

   divisor_sanitiser #(.WIDTH(WIDTH), .MIN_DIVISOR(MIN_DIVISOR)) u_sanitiser (
      .divisor_in  (frequency_divisor),
      .divisor_out (s_div)
   );

   assign terminal = (cnt == active_divisor - WIDTH'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         active_divisor <= WIDTH'(MIN_DIVISOR);
         sample_tick    <= 1'b0;
         tick_count     <= '0;
`ifdef SAMPLE_DIV_CLK_EN
         div_clk        <= 1'b0;
`endif
      end else if (restart) begin
         cnt            <= '0;
         active_divisor <= s_div;
         sample_tick    <= 1'b0;
         state          <= enable ? RUN : IDLE;
`ifdef SAMPLE_DIV_CLK_EN
         div_clk        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               sample_tick <= 1'b0;
`ifdef SAMPLE_DIV_CLK_EN
               div_clk     <= 1'b0;
`endif
               if (enable) begin
                  active_divisor <= s_div;
                  cnt            <= '0;
                  state          <= RUN;
               end
            end
            RUN, PAUSE: begin
               if (!enable) begin
                  state       <= PAUSE;
                  sample_tick <= 1'b0;
               end else begin
                  // The resume edge counts like any RUN edge, so a pause
                  // lengthens the period by exactly the paused cycles.
                  state <= RUN;
                  if (terminal) begin
                     cnt            <= '0;
                     sample_tick    <= 1'b1;
                     tick_count     <= tick_count + 16'd1;
                     active_divisor <= s_div;
`ifdef SAMPLE_DIV_CLK_EN
                     div_clk        <= 1'b1;
`endif
                  end else begin
                     cnt         <= cnt + WIDTH'(1);
                     sample_tick <= 1'b0;
`ifdef SAMPLE_DIV_CLK_EN
                     if (cnt + WIDTH'(1) == (active_divisor >> 1))
                        div_clk <= 1'b0;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sample_tick_generator.sv
// Directed bench for sample_tick_generator: vector table plus multi-cycle sequences.
module tb_sample_tick_generator;
   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        restart;
   logic [31:0] frequency_divisor;
   logic        sample_tick;
   logic [31:0] active_divisor;
   logic [15:0] tick_count;
`ifdef SAMPLE_DIV_CLK_EN
   logic        div_clk;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   sample_tick_generator #(.WIDTH(32), .MIN_DIVISOR(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .restart           (restart),
      .frequency_divisor (frequency_divisor),
      .sample_tick       (sample_tick),
      .active_divisor    (active_divisor),
      .tick_count        (tick_count)
`ifdef SAMPLE_DIV_CLK_EN
     ,.div_clk           (div_clk)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        rs;
      logic [31:0] div;
      logic        tick;
      logic [31:0] act;
      logic [15:0] tc;
   } vec_t;

   vec_t vt[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edges until sample_tick is seen high (bounded).
   task automatic measure(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!sample_tick && n < 5000);
   endtask

   initial begin
      int n;
      logic [15:0] tc_save;
      logic [4:0]  dc_pat;

      vt[0]  = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd2, 16'd0};
      vt[1]  = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd2, 16'd0};
      vt[2]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd2, 16'd1};
      vt[3]  = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd2, 16'd1};
      vt[4]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd2, 16'd2};
      vt[5]  = '{1'b1, 1'b0, 32'd1, 1'b0, 32'd2, 16'd2};
      vt[6]  = '{1'b1, 1'b0, 32'd1, 1'b1, 32'd2, 16'd3};
      vt[7]  = '{1'b1, 1'b0, 32'd3, 1'b0, 32'd2, 16'd3};
      vt[8]  = '{1'b1, 1'b0, 32'd3, 1'b1, 32'd3, 16'd4};
      vt[9]  = '{1'b1, 1'b0, 32'd3, 1'b0, 32'd3, 16'd4};
      vt[10] = '{1'b1, 1'b0, 32'd3, 1'b0, 32'd3, 16'd4};
      vt[11] = '{1'b1, 1'b0, 32'd3, 1'b1, 32'd3, 16'd5};
      vt[12] = '{1'b0, 1'b0, 32'd3, 1'b0, 32'd3, 16'd5};
      vt[13] = '{1'b0, 1'b0, 32'd3, 1'b0, 32'd3, 16'd5};
      vt[14] = '{1'b1, 1'b0, 32'd3, 1'b0, 32'd3, 16'd5};
      vt[15] = '{1'b1, 1'b0, 32'd3, 1'b0, 32'd3, 16'd5};
      vt[16] = '{1'b1, 1'b0, 32'd3, 1'b1, 32'd3, 16'd6};
      vt[17] = '{1'b0, 1'b1, 32'd7, 1'b0, 32'd7, 16'd6};
      vt[18] = '{1'b0, 1'b0, 32'd7, 1'b0, 32'd7, 16'd6};
      vt[19] = '{1'b1, 1'b0, 32'd5, 1'b0, 32'd5, 16'd6};

      reset = 1'b1; enable = 1'b0; restart = 1'b0; frequency_divisor = 32'd0;
      step(); step();
      chk("reset_tick", {31'd0, sample_tick}, 32'd0);
      chk("reset_active", active_divisor, 32'd2);
      chk("reset_count", {16'd0, tick_count}, 32'd0);
`ifdef SAMPLE_DIV_CLK_EN
      chk("reset_divclk", {31'd0, div_clk}, 32'd0);
`endif
      reset = 1'b0;
      step();
      chk("idle_hold_active", active_divisor, 32'd2);

      for (int i = 0; i < 20; i++) begin
         enable = vt[i].en; restart = vt[i].rs; frequency_divisor = vt[i].div;
         step();
         chk($sformatf("vec%0d_tick", i), {31'd0, sample_tick}, {31'd0, vt[i].tick});
         chk($sformatf("vec%0d_active", i), active_divisor, vt[i].act);
         chk($sformatf("vec%0d_count", i), {16'd0, tick_count}, {16'd0, vt[i].tc});
      end
      restart = 1'b0;

      // Async reset mid-period, checked between clock edges.
      step(); step();
      #2 reset = 1'b1;
      #1;
      chk("async_reset_active", active_divisor, 32'd2);
      chk("async_reset_count", {16'd0, tick_count}, 32'd0);
      chk("async_reset_tick", {31'd0, sample_tick}, 32'd0);
      step();
      frequency_divisor = 32'd1136; enable = 1'b1;
      reset = 1'b0;
      step();
      chk("leave_idle_active", active_divisor, 32'd1136);
      measure(n);
      chk("first_period_1136", n, 32'd1136);
      chk("count_after_first", {16'd0, tick_count}, 32'd1);
      measure(n);
      chk("second_period_1136", n, 32'd1136);
      chk("count_after_second", {16'd0, tick_count}, 32'd2);

      // Divisor change mid-period waits for the period boundary.
      frequency_divisor = 32'd10; restart = 1'b1; step(); restart = 1'b0;
      step(); step(); step();
      chk("chg_cnt3", dut.cnt, 32'd3);
      frequency_divisor = 32'd4;
      step();
      chk("chg_active_held", active_divisor, 32'd10);
      measure(n);
      chk("chg_period_10", n + 4, 32'd10);
      chk("chg_active_new", active_divisor, 32'd4);
      measure(n);
      chk("chg_period_4", n, 32'd4);

      // Pause of 7 cycles stretches a 10-cycle period to 17.
      frequency_divisor = 32'd10; restart = 1'b1; step(); restart = 1'b0;
      step(); step(); step();
      enable = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("pause_cnt_held", dut.cnt, 32'd3);
      enable = 1'b1;
      measure(n);
      chk("pause_period_17", n + 10, 32'd17);

      // Restart coincident with terminal count suppresses the tick.
      frequency_divisor = 32'd5; restart = 1'b1; step(); restart = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("rs_term_cnt", dut.cnt, 32'd4);
      tc_save = tick_count;
      restart = 1'b1; step(); restart = 1'b0;
      chk("rs_term_no_tick", {31'd0, sample_tick}, 32'd0);
      chk("rs_term_count_kept", {16'd0, tick_count}, {16'd0, tc_save});
      measure(n);
      chk("rs_term_next_5", n, 32'd5);

`ifdef SAMPLE_DIV_CLK_EN
      dc_pat[4] = div_clk;
      for (int i = 3; i >= 0; i--) begin
         step();
         dc_pat[i] = div_clk;
      end
      chk("divclk_pattern", {27'd0, dc_pat}, 32'b11000);
      step();
      chk("divclk_rise_with_tick", {30'd0, sample_tick, div_clk}, 32'b11);
`endif

      // Wrap of tick_count from 0xFFFF.
      frequency_divisor = 32'd2;
      measure(n);
      force dut.tick_count = 16'hFFFF;
      #1 release dut.tick_count;
      measure(n);
      chk("wrap_period", n, 32'd2);
      chk("wrap_count", {16'd0, tick_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sample_tick_generator.md
# sample_tick_generator

Converts the 32-bit `frequency_divisor` from the speed-control stage into a one-cycle `sample_tick` strobe every `frequency_divisor` system clocks, which paces audio sample fetch and playback. It sits directly downstream of the divisor generator and upstream of the sample-address/audio-output logic. Divisor changes take effect only at period boundaries, so a key press never produces a truncated or stretched period. An optional 50%-duty divided clock output is available.

## Interface
- `WIDTH`, 32: divisor and counter width.
- `MIN_DIVISOR`, 2: smallest period honoured. Smaller inputs are clamped up to this value.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: run when high, pause when low.
- `restart`  in  1: one-cycle pulse that aborts the current period and reloads the divisor.
- `frequency_divisor`  in  WIDTH: requested period in `clk` cycles.
- `sample_tick`  out  1: registered, one-cycle strobe at each period end.
- `active_divisor`  out  WIDTH: divisor currently being counted.
- `tick_count`  out  16: number of ticks since reset. Wraps modulo 2^16.
- `div_clk`  out  1: divided clock. Present only with the macro described under Configuration.

## Operation
- Sanitised divisor: `s = (frequency_divisor < MIN_DIVISOR) ? MIN_DIVISOR : frequency_divisor`.
- Internal registers: `cnt` (WIDTH) and `state` in {IDLE, RUN, PAUSE}.

State transitions, evaluated on each `clk` edge:
- **IDLE**, `enable`=1: `active_divisor` ← s, `cnt` ← 0, go to RUN.
- **IDLE**, `enable`=0: stay in IDLE.
- **RUN**, `enable`=0: go to PAUSE. `cnt` and `active_divisor` are held. `sample_tick` ← 0.
- **RUN**, `enable`=1, `cnt == active_divisor-1`:
  - `cnt` ← 0, `sample_tick` ← 1, `tick_count` ← `tick_count`+1.
  - `active_divisor` ← s. This is the only point where a new divisor is adopted.
- **RUN**, `enable`=1, otherwise: `cnt` ← `cnt`+1, `sample_tick` ← 0.
- **PAUSE**, `enable`=1: return to RUN. Counting resumes from the held `cnt`, so no period cycles are lost or added.

`restart` handling:
- `restart`=1 overrides everything above.
- Effect: `cnt` ← 0, `active_divisor` ← s, `sample_tick` ← 0.
- Next state is RUN if `enable`=1, otherwise IDLE.
- `tick_count` is not cleared.

Boundary rules:
- `restart` in the same cycle as terminal count: `restart` wins and no tick is issued.
- `tick_count` wraps from 0xFFFF to 0x0000 without any flag.
- Divisor `MAX` (all ones) is legal: the period is 2^WIDTH−1 cycles.
- `enable` dropping in the terminal-count cycle goes to PAUSE with `cnt` = D−1. The tick fires on the first RUN edge after resume.

Reset values: `state`=IDLE, `cnt`=0, `active_divisor`=`MIN_DIVISOR`, `sample_tick`=0, `tick_count`=0, `div_clk`=0.

## Timing
- Let edge E be the clock edge that leaves IDLE (or applies a `restart`) with divisor D.
- `sample_tick` is high in the cycle after edge E+D, then every D cycles while `enable` stays high.
- `sample_tick` is never high in two consecutive cycles, because D ≥ 2.
- Period change: a new `frequency_divisor` presented mid-period first affects the period that starts after the next tick.
- Pause cycles extend the current period by exactly the number of paused cycles.
- All outputs are registered and there is no combinational path from inputs to outputs.

## Configuration
- `SAMPLE_DIV_CLK_EN` defined:
  - `div_clk` port and register are compiled in.
  - `div_clk` ← 1 on each tick edge, and ← 0 on the edge where `cnt` becomes `active_divisor>>1`.
  - Result: high for floor(D/2) cycles and low for ceil(D/2) cycles.
  - Held during PAUSE. Forced to 0 in IDLE and on `restart`.
- `SAMPLE_DIV_CLK_EN` undefined: port, register and logic are absent. All other behaviour is identical.

## Structure
- The shared audio package holds:
  - the `tick_state_t` enum {IDLE, RUN, PAUSE};
  - `DEFAULT_DIVISOR` = 1136;
  - `MIN_DIVISOR` default.
- Sub-module `divisor_sanitiser`: combinational clamp to `MIN_DIVISOR`. It is reused by the speed-control stage.
- The FSM and counters stay in the top module.

## Test plan
- Reset, then `enable`=1 with divisor 1136: first `sample_tick` 1136 cycles after leaving IDLE, then every 1136 cycles; `tick_count` increments by 1 per tick.
- Divisor changed from 10 to 4 when `cnt`=3: the current period still lasts 10 cycles, and the following periods last 4.
- Divisor 0 or 1: `active_divisor`=2 and a tick every 2 cycles.
- `enable` low for 7 cycles mid-period with D=10: that period measures 17 cycles, and `cnt` is unchanged across the pause.
- `restart` coincident with terminal count at D=5: no tick that cycle, next tick 5 cycles later. Separately, asserting `reset` mid-period returns all outputs to their reset values immediately, without waiting for a clock edge.
- With `SAMPLE_DIV_CLK_EN` and D=5: `div_clk` is high for 2 cycles and low for 3, and rises in the same cycle as `sample_tick`. Force `tick_count` to 0xFFFF: the next tick wraps it to 0.
